// File: rtl/pwm_pkg.sv
// Shared counter/PWM constants: default bus widths, count direction and FSM encoding.
package pwm_pkg;

   localparam int   CNT_W_DEF = 16;
   localparam int   PSC_W_DEF = 8;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk by act_psc+1: tick is a combinational strobe in the cycle the count matches.
// Latency: tick in the same cycle the count equals act_psc; clear has priority and takes effect next edge.
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int PSC_W = PSC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [PSC_W-1:0] act_psc,
   output logic             tick
);

   logic [PSC_W-1:0] r_cnt;

   assign tick = en && (r_cnt == act_psc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear || tick) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_counter.sv
// Up/down timebase for the PWM generator with shadowed period/prescale/direction and a wrap pulse.
// count_val and period_done are registered; settings are sampled only on start, wrap or count_reset.
module pwm_counter
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int PSC_W = PSC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             count_en,
   input  logic             count_reset,
   input  logic [CNT_W-1:0] period,
   input  logic [PSC_W-1:0] prescale,
   input  logic             upnotdown,
   output logic [CNT_W-1:0] count_val,
   output logic             period_done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_psc_clr;
   logic             w_psc_en;
   logic             w_tick;
   logic             w_wrap;
   logic [CNT_W-1:0] w_cnt_nxt;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_period;
   logic [PSC_W-1:0] r_psc;
   logic             r_dir;
   logic             r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_psc_clr   = 1'b0;
      w_psc_en    = 1'b0;
      case (r_state)
         IDLE: begin
            if (count_en) begin
               w_state_nxt = RUN;
               w_load      = 1'b1;
               w_psc_clr   = 1'b1;
            end
         end
         RUN: begin
            if (count_en) begin
               w_psc_en = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // A clear suppresses any tick in the same cycle, so no wrap pulse can escape.
      if (count_reset) begin
         w_state_nxt = r_state;
         w_load      = 1'b1;
         w_psc_clr   = 1'b1;
         w_psc_en    = 1'b0;
      end
   end

   pwm_prescaler #(
      .PSC_W (PSC_W)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_psc_clr),
      .en      (w_psc_en),
      .act_psc (r_psc),
      .tick    (w_tick)
   );

   always_comb begin
      w_wrap    = 1'b0;
      w_cnt_nxt = r_cnt;
      if (w_tick) begin
         if (r_dir == DIR_DOWN) begin
            w_wrap    = (r_cnt == '0);
            w_cnt_nxt = w_wrap ? r_period : r_cnt - 1'b1;
         end else begin
            // A count left above a shrunken period runs on to the natural overflow.
            w_wrap    = (r_cnt == r_period) || (r_cnt == '1);
            w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_period <= '0;
         r_psc    <= '0;
         r_dir    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_wrap;
         if (count_reset) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= w_cnt_nxt;
         end
         if (w_load || w_wrap) begin
            r_period <= period;
            r_psc    <= prescale;
            r_dir    <= upnotdown;
         end
      end
   end

   assign count_val   = r_cnt;
   assign period_done = r_done;

endmodule

// File: tb/tb_pwm_counter.sv
// Directed bench for pwm_counter: hand-computed count/wrap sequences checked with immediate assertions.
module tb_pwm_counter;
   import pwm_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        count_en;
   logic        count_reset;
   logic [15:0] period;
   logic [7:0]  prescale;
   logic        upnotdown;
   logic [15:0] count_val;
   logic        period_done;

   int checks = 0;
   int errors = 0;

   int   t2_cnt [11] = '{0, 0, 3, 3, 2, 2, 1, 1, 0, 0, 3};
   logic t2_done[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
   int   t3_cnt [10] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 0};
   logic t3_done[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1};

   pwm_counter #(
      .CNT_W (16),
      .PSC_W (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .count_en    (count_en),
      .count_reset (count_reset),
      .period      (period),
      .prescale    (prescale),
      .upnotdown   (upnotdown),
      .count_val   (count_val),
      .period_done (period_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int exp_cnt, input logic exp_done);
      checks++;
      assert (count_val === 16'(exp_cnt)) else begin
         errors++;
         $error("FAIL %s count_val=%0d expected %0d", tag, count_val, exp_cnt);
      end
      checks++;
      assert (period_done === exp_done) else begin
         errors++;
         $error("FAIL %s period_done=%0b expected %0b", tag, period_done, exp_done);
      end
   endtask

   task automatic check_idle(input string tag);
      checks++;
      assert (dut.r_state === IDLE) else begin
         errors++;
         $error("FAIL %s state=%0d expected IDLE", tag, dut.r_state);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      count_en    = 1'b0;
      count_reset = 1'b0;
      period      = 16'd3;
      prescale    = 8'd0;
      upnotdown   = 1'b1;
      #12;
      check("reset", 0, 1'b0);
      check_idle("reset_state");
      rst_n = 1'b1;
      step();
      check("idle_no_en", 0, 1'b0);
      check_idle("idle_no_en_state");

      // up, period 3, prescale 0
      count_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         check($sformatf("up_p3_%0d", i), (i == 0) ? 0 : i % 4, (i > 0) && (i % 4 == 0));
      end

      // down, period 3, prescale 1, restarted from 0 by count_reset
      count_reset = 1'b1;
      upnotdown   = 1'b0;
      prescale    = 8'd1;
      for (int k = 0; k < 11; k++) begin
         step();
         if (k == 0) count_reset = 1'b0;
         check($sformatf("down_p3_%0d", k), t2_cnt[k], t2_done[k]);
      end

      // up, period 5 changed to 2 mid-cycle
      count_reset = 1'b1;
      upnotdown   = 1'b1;
      period      = 16'd5;
      prescale    = 8'd0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (k == 0) count_reset = 1'b0;
         if (k == 1) period = 16'd2;
         check($sformatf("shadow_%0d", k), t3_cnt[k], t3_done[k]);
      end

      // count_reset colliding with a wrapping tick at count_val=2
      step();
      check("pre_clr_1", 1, 1'b0);
      step();
      check("pre_clr_2", 2, 1'b0);
      count_reset = 1'b1;
      step();
      count_reset = 1'b0;
      check("clr_vs_tick", 0, 1'b0);

      // prescale 2: pause with count_en low at count_val=4
      count_reset = 1'b1;
      period      = 16'd9;
      prescale    = 8'd2;
      step();
      count_reset = 1'b0;
      check("psc2_clr", 0, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         step();
         check($sformatf("psc2_run_%0d", i), i / 3, 1'b0);
      end
      count_en = 1'b0;
      for (int i = 0; i < 11; i++) begin
         step();
         check($sformatf("pause_%0d", i), 4, 1'b0);
      end
      count_en = 1'b1;
      step();
      check("resume_entry", 4, 1'b0);
      step();
      check("resume_1", 4, 1'b0);
      step();
      check("resume_2", 4, 1'b0);
      step();
      check("resume_3", 5, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         step();
         check($sformatf("to7_%0d", i), 5 + i / 3, 1'b0);
      end

      // asynchronous reset between edges at count_val=7
      #2;
      rst_n    = 1'b0;
      count_en = 1'b0;
      #1;
      check("async_rst", 0, 1'b0);
      check_idle("async_rst_state");
      #2;
      rst_n = 1'b1;
      step();
      check("post_rst_idle", 0, 1'b0);
      check_idle("post_rst_state");

      // period 0: stays at 0, pulses every tick
      period    = 16'd0;
      prescale  = 8'd0;
      upnotdown = 1'b1;
      count_en  = 1'b1;
      step();
      check("p0_entry", 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("p0_tick_%0d", i), 0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
